// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Purpose  : Shared types, opcode constants and the opcode classifier for
//             the RV32I decode-stage controller.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Immediate format selected for the instruction in decode.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    // Occupancy of the single-entry ID/EX register.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        LU_WAIT = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Everything decode needs to know about an opcode.
    typedef struct packed {
        imm_sel_e imm_sel;
        logic     illegal;
        logic     rs1_used;
        logic     rs2_used;
        logic     is_load;
    } dec_info_t;

    // Contents of the ID/EX register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        imm_sel_e    imm_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_load;
        logic        illegal;
    } ex_payload_t;

    // Map a 7-bit opcode onto its immediate format and register usage.
    function automatic dec_info_t classify(input logic [6:0] opcode);
        dec_info_t info;
        info.imm_sel  = IMM_NONE;
        info.illegal  = 1'b0;
        info.rs1_used = 1'b0;
        info.rs2_used = 1'b0;
        info.is_load  = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                info.imm_sel  = IMM_I;
                info.rs1_used = 1'b1;
                info.is_load  = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: begin
                info.imm_sel  = IMM_I;
                info.rs1_used = 1'b1;
            end
            OPC_STORE: begin
                info.imm_sel  = IMM_S;
                info.rs1_used = 1'b1;
                info.rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                info.imm_sel  = IMM_B;
                info.rs1_used = 1'b1;
                info.rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: info.imm_sel = IMM_U;
            OPC_JAL:            info.imm_sel = IMM_J;
            OPC_OP: begin
                info.rs1_used = 1'b1;
                info.rs2_used = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: info.imm_sel = IMM_NONE;
            default:                  info.illegal = 1'b1;
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen
//  Purpose  : Produces all five sign-extended RV32I immediates in parallel
//             from the instruction word; the caller selects one.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen (
    input  logic [31:7] i_instr,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_u,
    output logic [31:0] o_imm_j
);

    // Bit-field reassembly for each format; the opcode bits are not needed.
    always_comb begin
        o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
        o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
        o_imm_u = {i_instr[31:12], 12'b0};
        o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decode_ctrl
//  Purpose  : RV32I decode-stage controller. Classifies fetched instructions,
//             selects the immediate, fills the single-entry ID/EX register
//             and inserts one bubble on a load-use hazard.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_ready,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [31:0]      ex_instr,
    output logic [XLEN-1:0]  ex_imm,
    output logic [2:0]       ex_imm_sel,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_is_load,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    state_e           state_q, state_d;
    logic             ex_valid_q, ex_valid_d;
    ex_payload_t      payload_q, payload_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    dec_info_t   w_info;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_imm;
    logic        w_hazard;
    logic        w_accept;
    logic        w_cnt_inc;

    imm_gen u_imm_gen (
        .i_instr (if_instr[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    // Decode the incoming word and test it against a load sitting in ID/EX.
    always_comb begin
        w_info   = classify(if_instr[6:0]);
        w_rs1    = if_instr[19:15];
        w_rs2    = if_instr[24:20];
        w_rd     = if_instr[11:7];
        w_hazard = ex_valid_q && payload_q.is_load && (payload_q.rd != 5'd0) &&
                   ((w_info.rs1_used && (w_rs1 == payload_q.rd)) ||
                    (w_info.rs2_used && (w_rs2 == payload_q.rd)));
        if_ready = !flush && !w_hazard && (!ex_valid_q || ex_ready);
        w_accept = if_valid && if_ready;
    end

    // Pick the immediate matching the decoded format; formats without one give 0.
    always_comb begin
        case (w_info.imm_sel)
            IMM_I:   w_imm = w_imm_i;
            IMM_S:   w_imm = w_imm_s;
            IMM_B:   w_imm = w_imm_b;
            IMM_U:   w_imm = w_imm_u;
            IMM_J:   w_imm = w_imm_j;
            default: w_imm = 32'd0;
        endcase
    end

    // Next-state, payload load and stall-counter update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) state_d = FULL;
            end
            FULL: begin
                // A load consumed this cycle cannot be held back, so ex_ready
                // outranks the hazard: the dependant simply enters behind a
                // bubble. LU_WAIT is only for a load that EX is not taking.
                if (flush)                      state_d = EMPTY;
                else if (ex_ready)              state_d = w_accept ? FULL : EMPTY;
                else if (w_hazard && if_valid)  state_d = LU_WAIT;
            end
            LU_WAIT: begin
                if (flush || ex_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        ex_valid_d = (state_d != EMPTY);

        payload_d = payload_q;
        if (w_accept) begin
            payload_d.pc      = if_pc;
            payload_d.instr   = if_instr;
            payload_d.imm     = w_imm;
            payload_d.imm_sel = w_info.imm_sel;
            payload_d.rs1     = w_rs1;
            payload_d.rs2     = w_rs2;
            payload_d.rd      = w_rd;
            payload_d.is_load = w_info.is_load;
            payload_d.illegal = w_info.illegal;
        end

        w_cnt_inc = (state_q == LU_WAIT) ||
                    ((state_q == FULL) && w_hazard && if_valid && !flush);
        cnt_d     = (w_cnt_inc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State and output registers; reset wins over flush and accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            ex_valid_q <= 1'b0;
            payload_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            payload_q  <= payload_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = payload_q.pc;
    assign ex_instr     = payload_q.instr;
    assign ex_imm       = payload_q.imm;
    assign ex_imm_sel   = payload_q.imm_sel;
    assign ex_rs1       = payload_q.rs1;
    assign ex_rs2       = payload_q.rs2;
    assign ex_rd        = payload_q.rd;
    assign ex_is_load   = payload_q.is_load;
    assign ex_illegal   = payload_q.illegal;
    assign lu_stall_cnt = cnt_q;

endmodule
`default_nettype wire
